// File: rtl/bch_31_encoder.sv
`default_nettype none
// ============================================================================
// Module      : bch_31_encoder
// Description : Systematic BCH(31,21) encoder over GF(2^5), p(x)=x^5+x^2+1.
//               Bit-serial LFSR division, one message bit per clock, with an
//               XOR error mask on the presented codeword and a valid/ready
//               handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module bch_31_encoder #(
  parameter int          N   = 31,
  parameter int          K   = 21,
  parameter logic [10:0] GEN = 11'h769
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [K-1:0] msg,
  input  logic [N-1:0] err_mask,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] cw,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  // Index of the final message bit; the shift phase ends on this count.
  localparam logic [4:0] LAST_CNT = 5'(K - 1);

  logic [1:0]     state;
  logic [9:0]     lfsr;
  logic [4:0]     cnt;
  logic [K-1:0]   msg_reg;
  logic [N-1:0]   mask_reg;

  logic           bit_in;
  logic           fb;
  logic [9:0]     lfsr_next;

  // One division step: message enters MSB first, feedback folds in g(x) low bits.
  always_comb begin
    bit_in    = msg_reg[LAST_CNT - cnt];
    fb        = bit_in ^ lfsr[9];
    lfsr_next = {lfsr[8:0], 1'b0} ^ (fb ? GEN[9:0] : 10'h000);
  end

  // Control FSM plus datapath registers; reset discards any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= '0;
      cnt      <= '0;
      msg_reg  <= '0;
      mask_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            msg_reg  <= msg;
            mask_reg <= err_mask;
            lfsr     <= '0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          lfsr <= lfsr_next;
          if (cnt == LAST_CNT) begin
            // Counter parks at zero so it never runs past the last bit index.
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode directly from state; codeword is forced to zero outside DONE.
  always_comb begin
    in_ready  = (state == IDLE) & ~rst;
    out_valid = (state == DONE);
    busy      = (state == SHIFT);
    cw        = (state == DONE) ? ({msg_reg, lfsr} ^ mask_reg) : '0;
  end

endmodule
`default_nettype wire
